ssd_page_display: RTL

//  Downstream display stage of the FPGA top: consumes the 32-bit display word and drives six

---
 rtl/ssd_page_display.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ssd_page_display.sv
`default_nettype none
// ============================================================================
// Module   : ssd_page_display
// Desc     : Shows a captured 32-bit word on six active-low seven-segment
//            digits as two alternating pages (low 24 bits / high 8 bits).
//            Optional leading-zero blanking: define SSD_PAGE_DISPLAY_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_page_display #(
    parameter int PAGE_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        hold,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        page_o
);

    // Segment bit 6 is segment a, bit 0 is segment g.
    localparam logic [6:0]       c_BLANK    = 7'b1111111;
    localparam logic [6:0]       c_H_MARKER = 7'b1001000;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(PAGE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAGE_LO = 2'd1,
        PAGE_HI = 2'd2
    } state_t;

    state_t             r_state, w_stateNext;
    logic [CNT_W-1:0]   r_cnt, w_cntNext;
    logic [31:0]        r_dataQ, w_dataNext;
    logic [6:0]         w_hex [0:5];
    logic               w_page;
`ifdef SSD_PAGE_DISPLAY_LZB_EN
    logic               w_lead;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dataQ <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_dataQ <= w_dataNext;
        end
    end

    // Next state: load beats hold, and hold beats dwell expiry.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_dataNext  = r_dataQ;
        if (load) begin
            w_dataNext  = data_in;
            w_stateNext = PAGE_LO;
            w_cntNext   = '0;
        end else if (!hold) begin
            case (r_state)
                PAGE_LO: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cntNext = '0;
                        if (r_dataQ[31:24] != 8'h00) w_stateNext = PAGE_HI;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                PAGE_HI: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cntNext   = '0;
                        w_stateNext = PAGE_LO;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display decode from the current state; registered below for one cycle of latency.
    always_comb begin
        for (int i = 0; i < 6; i++) w_hex[i] = c_BLANK;
        w_page = 1'b0;
`ifdef SSD_PAGE_DISPLAY_LZB_EN
        w_lead = 1'b1;
`endif
        case (r_state)
            PAGE_LO: begin
                for (int i = 0; i < 6; i++) w_hex[i] = glyph(r_dataQ[4*i +: 4]);
`ifdef SSD_PAGE_DISPLAY_LZB_EN
                for (int i = 5; i >= 1; i--) begin
                    if (r_dataQ[4*i +: 4] != 4'h0) w_lead = 1'b0;
                    if (w_lead) w_hex[i] = c_BLANK;
                end
`endif
            end
            PAGE_HI: begin
                w_page   = 1'b1;
                w_hex[0] = glyph(r_dataQ[27:24]);
                w_hex[1] = glyph(r_dataQ[31:28]);
                w_hex[5] = c_H_MARKER;
`ifdef SSD_PAGE_DISPLAY_LZB_EN
                if (r_dataQ[31:28] == 4'h0) w_hex[1] = c_BLANK;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HEX0   <= c_BLANK;
            HEX1   <= c_BLANK;
            HEX2   <= c_BLANK;
            HEX3   <= c_BLANK;
            HEX4   <= c_BLANK;
            HEX5   <= c_BLANK;
            page_o <= 1'b0;
        end else begin
            HEX0   <= w_hex[0];
            HEX1   <= w_hex[1];
            HEX2   <= w_hex[2];
            HEX3   <= w_hex[3];
            HEX4   <= w_hex[4];
            HEX5   <= w_hex[5];
            page_o <= w_page;
        end
    end

endmodule
`default_nettype wire
